run_hls_deadlock_confirm_unit: RTL and testbench
================================================

Name: run_hls_deadlock_confirm_unit

Overview:
Per-process deadlock detection node for HLS dataflow regions, next generation of the dependency-propagation unit. Propagates the blocked-process dependency set along output channels and detects a self-dependency cycle. Only reports a deadlock after the cycle has persisted for a programmable number of consecutive cycles. Adds a captured report vector, host acknowledge, and a blocked-duration counter. One instance per dataflow process; nodes are chained through the channel dependency and token ports.

Parameters:
PROC_NUM, 4, number of processes in the region; width of a dependency vector
PROC_ID, 0, index of this process, 0..PROC_NUM-1
IN_CHAN_NUM, 2, number of input dependency channels, >=1
OUT_CHAN_NUM, 3, number of output dependency channels, >=1
CONFIRM_CYCLES, 8, consecutive cycle-hit cycles required before reporting, >=1
CNT_W, 16, width of stall_cnt

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
proc_dep_vld_vec  in  OUT_CHAN_NUM  process blocked on output channel i
in_chan_dep_vld_vec  in  IN_CHAN_NUM  upstream dependency valid per input channel
in_chan_dep_data_vec  in  IN_CHAN_NUM*PROC_NUM  upstream dependency sets, channel i at [i*PROC_NUM +: PROC_NUM]
token_in_vec  in  IN_CHAN_NUM  report token from upstream
dl_detect_in  in  1  global deadlock-detected flag
origin  in  1  this node originates the report token
token_clear  in  1  kill token propagation
dl_ack  in  1  host acknowledge of report
out_chan_dep_vld_vec  out  OUT_CHAN_NUM  combinational copy of proc_dep_vld_vec
out_chan_dep_data  out  PROC_NUM  dep_reg | (1<<PROC_ID), combinational
token_out_vec  out  OUT_CHAN_NUM  registered report token
dl_detect_out  out  1  registered confirmed-deadlock flag
dl_report_dep  out  PROC_NUM  dependency set captured at confirmation
stall_cnt  out  CNT_W  consecutive blocked cycles, saturating

Behaviour:
- Reset (sync, high): dep_reg, token_out_vec, dl_detect_out, dl_report_dep, stall_cnt, conf_cnt = 0; state IDLE. Reset mid-operation aborts any confirm/report in the next cycle.
- blocked = |proc_dep_vld_vec. upd = ~dl_detect_in | |token_in_vec.
- dep_comb = OR over i of ({PROC_NUM{in_chan_dep_vld_vec[i]}} & data_i).
- dep_sel = upd ? dep_comb : dep_reg.
- dep_reg <= blocked ? dep_sel : 0.
- hit = upd & blocked & dep_sel[PROC_ID], combinational.
- FSM states IDLE, CONFIRM, REPORT:
  - IDLE: on hit, conf_cnt<=1; go to REPORT if CONFIRM_CYCLES==1, else CONFIRM.
  - CONFIRM: on ~hit, go to IDLE and set conf_cnt<=0. On hit with conf_cnt==CONFIRM_CYCLES-1, go to REPORT. Otherwise conf_cnt++.
  - On every transition into REPORT: dl_report_dep <= dep_sel.
  - REPORT: exit to IDLE on dl_ack or ~blocked (same result if both). Otherwise stay.
- dl_detect_out = registered (state==REPORT).
  - Rises exactly CONFIRM_CYCLES cycles after the first of CONFIRM_CYCLES consecutive hit cycles.
  - Falls the cycle after the exit condition.
- dl_ack outside REPORT is ignored.
- dl_report_dep holds its value until the next capture or reset.
- conf_cnt width is clog2(CONFIRM_CYCLES+1).
- token_out_vec <= ((|token_in_vec & ~token_clear) | origin) ? proc_dep_vld_vec : 0.
  - origin overrides token_clear.
- stall_cnt <= blocked ? sat_inc(stall_cnt) : 0. Saturates at 2^CNT_W-1 with no wrap.

Optional Feature:
DL_STALL_CNT_EN
- Defined: stall_cnt counter implemented as above.
- Undefined: no counter register; stall_cnt tied to 0.
- All other behaviour identical in both builds.

Test Plan:
- Common setup: PROC_NUM=4, PROC_ID=0, IN=2, OUT=3, CONFIRM_CYCLES=3, CNT_W=4, DL_STALL_CNT_EN defined.
- Reset: reset=1 for 2 cycles with random inputs -> all registered outputs 0, state IDLE, out_chan_dep_data=4'b0001.
- Confirm: proc_dep_vld_vec=3'b001, in_chan_dep_vld_vec=2'b01, chan0 data=4'b0011, dl_detect_in=0, all from cycle t -> dl_detect_out=0 at t+1 and t+2, 1 at t+3; dl_report_dep=4'b0011. dl_ack=1 at t+5 -> dl_detect_out=0 at t+6.
- Glitch filter: same stimulus held for 2 cycles only, then chan0 data=4'b0010 -> dl_detect_out never asserts; FSM back in IDLE.
- Token gating:
  - dl_detect_in=1, token_in_vec=0, new chan data -> dep_reg unchanged, hit=0.
  - token_in_vec=2'b10, token_clear=0 -> dep_reg updates; token_out_vec=proc_dep_vld_vec next cycle.
  - token_clear=1 -> token_out_vec=0.
  - origin=1 with token_clear=1 -> token_out_vec=proc_dep_vld_vec.
- Dissolve: in REPORT, proc_dep_vld_vec->0 -> dl_detect_out=0 and dep_reg=0 next cycle; dl_report_dep retained.
- Stall counter:
  - Blocked for 20 cycles -> stall_cnt saturates at 15.
  - Unblock -> stall_cnt=0 next cycle.
  - Rebuild without DL_STALL_CNT_EN -> stall_cnt constant 0.

Source files
------------

// File: rtl/run_hls_deadlock_confirm_unit_if.sv
// Channel, token and report signals of one deadlock confirm node.
// slave is the node's view; master is the view of whatever drives the node.
interface run_hls_deadlock_confirm_unit_if #(
    parameter int PROC_NUM     = 4,
    parameter int IN_CHAN_NUM  = 2,
    parameter int OUT_CHAN_NUM = 3,
    parameter int CNT_W        = 16
);
    logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec;
    logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec;
    logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
    logic [IN_CHAN_NUM-1:0]          token_in_vec;
    logic                            dl_detect_in;
    logic                            origin;
    logic                            token_clear;
    logic                            dl_ack;
    logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec;
    logic [PROC_NUM-1:0]             out_chan_dep_data;
    logic [OUT_CHAN_NUM-1:0]         token_out_vec;
    logic                            dl_detect_out;
    logic [PROC_NUM-1:0]             dl_report_dep;
    logic [CNT_W-1:0]                stall_cnt;

    modport slave (
        input  proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
        input  dl_detect_in, origin, token_clear, dl_ack,
        output out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out,
        output dl_report_dep, stall_cnt
    );

    modport master (
        output proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
        output dl_detect_in, origin, token_clear, dl_ack,
        input  out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out,
        input  dl_report_dep, stall_cnt
    );
endinterface

// File: rtl/run_hls_deadlock_confirm_unit.sv
// Per-process deadlock node: propagates blocked dependency sets and reports a self-cycle
// only after it persists CONFIRM_CYCLES cycles. Define DL_STALL_CNT_EN to build the stall counter.
module run_hls_deadlock_confirm_unit #(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 8,
    parameter int CNT_W          = 16
) (
    input logic                           clock,
    input logic                           reset,
    run_hls_deadlock_confirm_unit_if.slave bus
);
    localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;
    localparam logic [CONF_W-1:0]   CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        REPORT
    } state_t;

    state_t                  r_state;
    logic [CONF_W-1:0]       r_confCnt;
    logic [PROC_NUM-1:0]     r_depReg;
    logic [PROC_NUM-1:0]     r_reportDep;
    logic                    r_detect;
    logic [OUT_CHAN_NUM-1:0] r_tokenOut;

    logic                    w_blocked;
    logic                    w_upd;
    logic [PROC_NUM-1:0]     w_depComb;
    logic [PROC_NUM-1:0]     w_depSel;
    logic                    w_hit;
    logic                    w_tokenPass;

    assign w_blocked   = |bus.proc_dep_vld_vec;
    // Once a deadlock is flagged globally, sets only move while the report token is present.
    assign w_upd       = ~bus.dl_detect_in | (|bus.token_in_vec);
    assign w_depSel    = w_upd ? w_depComb : r_depReg;
    assign w_hit       = w_upd & w_blocked & w_depSel[PROC_ID];
    assign w_tokenPass = ((|bus.token_in_vec) & ~bus.token_clear) | bus.origin;

    always_comb begin
        w_depComb = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            w_depComb = w_depComb |
                ({PROC_NUM{bus.in_chan_dep_vld_vec[i]}} & bus.in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_depReg   <= '0;
            r_tokenOut <= '0;
        end else begin
            r_depReg   <= w_blocked ? w_depSel : '0;
            r_tokenOut <= w_tokenPass ? bus.proc_dep_vld_vec : '0;
        end
    end

    // r_detect is updated alongside the state so it is high exactly while in REPORT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_confCnt   <= '0;
            r_detect    <= 1'b0;
            r_reportDep <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_confCnt <= CONF_W'(1);
                        if (CONFIRM_CYCLES == 1) begin
                            r_state     <= REPORT;
                            r_detect    <= 1'b1;
                            r_reportDep <= w_depSel;
                        end else begin
                            r_state <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (!w_hit) begin
                        r_state   <= IDLE;
                        r_confCnt <= '0;
                    end else if (r_confCnt == CONF_LAST) begin
                        r_state     <= REPORT;
                        r_detect    <= 1'b1;
                        r_reportDep <= w_depSel;
                    end else begin
                        r_confCnt <= r_confCnt + CONF_W'(1);
                    end
                end
                REPORT: begin
                    if (bus.dl_ack || !w_blocked) begin
                        r_state   <= IDLE;
                        r_detect  <= 1'b0;
                        r_confCnt <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_detect  <= 1'b0;
                    r_confCnt <= '0;
                end
            endcase
        end
    end

`ifdef DL_STALL_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;

    always_ff @(posedge clock) begin
        if (reset || !w_blocked) begin
            r_stallCnt <= '0;
        end else if (r_stallCnt != {CNT_W{1'b1}}) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stallCnt;
`else
    assign bus.stall_cnt = '0;
`endif

    assign bus.out_chan_dep_vld_vec = bus.proc_dep_vld_vec;
    assign bus.out_chan_dep_data    = r_depReg | SELF_BIT;
    assign bus.token_out_vec        = r_tokenOut;
    assign bus.dl_detect_out        = r_detect;
    assign bus.dl_report_dep        = r_reportDep;
endmodule

// File: tb/tb_run_hls_deadlock_confirm_unit.sv
// Scoreboard bench for run_hls_deadlock_confirm_unit: each directed vector queues the outputs
// expected after its clock edge; a monitor pops and compares one entry per cycle.
module tb_run_hls_deadlock_confirm_unit;
    localparam int PROC_NUM       = 4;
    localparam int PROC_ID        = 0;
    localparam int IN_CHAN_NUM    = 2;
    localparam int OUT_CHAN_NUM   = 3;
    localparam int CONFIRM_CYCLES = 3;
    localparam int CNT_W          = 4;

    typedef struct {
        string      name;
        logic [2:0] vld;
        logic [3:0] data;
        logic [2:0] tok;
        logic       det;
        logic [3:0] rep;
        logic [3:0] stall;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t expQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    run_hls_deadlock_confirm_unit_if #(
        .PROC_NUM(PROC_NUM), .IN_CHAN_NUM(IN_CHAN_NUM),
        .OUT_CHAN_NUM(OUT_CHAN_NUM), .CNT_W(CNT_W)
    ) bus ();

    run_hls_deadlock_confirm_unit #(
        .PROC_NUM(PROC_NUM), .PROC_ID(PROC_ID), .IN_CHAN_NUM(IN_CHAN_NUM),
        .OUT_CHAN_NUM(OUT_CHAN_NUM), .CONFIRM_CYCLES(CONFIRM_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input string field, input logic [7:0] act, input logic [7:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s.%s: got %0h, required %0h", name, field, act, req);
        end
    endtask

    task automatic applyStimulus(
        input string name, input logic rst, input logic [2:0] pdv, input logic [1:0] icv,
        input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] tin,
        input logic dli, input logic org, input logic tclr, input logic ack,
        input logic expDet, input logic [3:0] expRep, input logic [2:0] expTok,
        input logic [3:0] expData, input logic [3:0] expStall
    );
        exp_t e;
        @(negedge clock);
        reset                    = rst;
        bus.proc_dep_vld_vec     = pdv;
        bus.in_chan_dep_vld_vec  = icv;
        bus.in_chan_dep_data_vec = {d1, d0};
        bus.token_in_vec         = tin;
        bus.dl_detect_in         = dli;
        bus.origin               = org;
        bus.token_clear          = tclr;
        bus.dl_ack               = ack;
        e.name  = name;
        e.vld   = pdv;
        e.data  = expData;
        e.tok   = expTok;
        e.det   = expDet;
        e.rep   = expRep;
`ifdef DL_STALL_CNT_EN
        e.stall = expStall;
`else
        e.stall = (expStall == 4'd0) ? 4'd0 : 4'd0;
`endif
        expQ.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, "vld",   8'(bus.out_chan_dep_vld_vec), 8'(e.vld));
                checkOutput(e.name, "data",  8'(bus.out_chan_dep_data),    8'(e.data));
                checkOutput(e.name, "tok",   8'(bus.token_out_vec),        8'(e.tok));
                checkOutput(e.name, "det",   8'(bus.dl_detect_out),        8'(e.det));
                checkOutput(e.name, "rep",   8'(bus.dl_report_dep),        8'(e.rep));
                checkOutput(e.name, "stall", 8'(bus.stall_cnt),            8'(e.stall));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.proc_dep_vld_vec     = '0;
        bus.in_chan_dep_vld_vec  = '0;
        bus.in_chan_dep_data_vec = '0;
        bus.token_in_vec         = '0;
        bus.dl_detect_in         = 1'b0;
        bus.origin               = 1'b0;
        bus.token_clear          = 1'b0;
        bus.dl_ack               = 1'b0;

        for (int k = 0; k < 2; k++) begin
            applyStimulus("reset", 1'b1, 3'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'b0, 4'b0000, 3'b000, 4'b0001, 4'd0);
        end

        applyStimulus("confirm1", 0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 4'b0011, 4'd1);
        applyStimulus("confirm2", 0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 4'b0011, 4'd2);
        applyStimulus("confirm3", 0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0011, 3'b000, 4'b0011, 4'd3);
        applyStimulus("report4",  0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0011, 3'b000, 4'b0011, 4'd4);
        applyStimulus("report5",  0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0011, 3'b000, 4'b0011, 4'd5);
        applyStimulus("ack",      0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 4'b0011, 3'b000, 4'b0011, 4'd6);
        applyStimulus("unblock",  0, 3'b000, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0001, 4'd0);

        applyStimulus("glitch1",  0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0011, 4'd1);
        applyStimulus("glitch2",  0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0011, 4'd2);
        applyStimulus("glitch3",  0, 3'b001, 2'b01, 4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0011, 4'd3);
        applyStimulus("glitch4",  0, 3'b001, 2'b01, 4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0011, 4'd4);
        applyStimulus("glitch5",  0, 3'b001, 2'b01, 4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0011, 4'd5);
        applyStimulus("idleAck",  0, 3'b001, 2'b01, 4'b0111, 4'b0000, 2'b00, 0, 0, 0, 1, 0, 4'b0011, 3'b000, 4'b0111, 4'd6);
        applyStimulus("refill2",  0, 3'b001, 2'b01, 4'b0111, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0111, 4'd7);
        applyStimulus("refill3",  0, 3'b001, 2'b01, 4'b0111, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0111, 3'b000, 4'b0111, 4'd8);
        applyStimulus("dissolve", 0, 3'b000, 2'b01, 4'b0111, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0111, 3'b000, 4'b0001, 4'd0);

        applyStimulus("tokSeed",  0, 3'b001, 2'b01, 4'b0101, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0111, 3'b000, 4'b0101, 4'd1);
        applyStimulus("tokHold",  0, 3'b001, 2'b01, 4'b1010, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 4'b0111, 3'b000, 4'b0101, 4'd2);
        applyStimulus("tokPass",  0, 3'b011, 2'b01, 4'b1010, 4'b0000, 2'b10, 1, 0, 0, 0, 0, 4'b0111, 3'b011, 4'b1011, 4'd3);
        applyStimulus("tokClear", 0, 3'b101, 2'b01, 4'b1010, 4'b0000, 2'b10, 1, 0, 1, 0, 0, 4'b0111, 3'b000, 4'b1011, 4'd4);
        applyStimulus("tokOrig",  0, 3'b110, 2'b01, 4'b1010, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 4'b0111, 3'b110, 4'b1011, 4'd5);

        applyStimulus("chan1",    0, 3'b001, 2'b10, 4'b0001, 4'b0100, 2'b00, 0, 0, 0, 0, 0, 4'b0111, 3'b000, 4'b0101, 4'd6);
        applyStimulus("chanOr1",  0, 3'b001, 2'b11, 4'b0001, 4'b0100, 2'b00, 0, 0, 0, 0, 0, 4'b0111, 3'b000, 4'b0101, 4'd7);
        applyStimulus("chanOr2",  0, 3'b001, 2'b11, 4'b0001, 4'b0100, 2'b00, 0, 0, 0, 0, 0, 4'b0111, 3'b000, 4'b0101, 4'd8);
        applyStimulus("chanOr3",  0, 3'b001, 2'b11, 4'b0001, 4'b0100, 2'b00, 0, 0, 0, 0, 1, 4'b0101, 3'b000, 4'b0101, 4'd9);
        applyStimulus("ackUnblk", 0, 3'b000, 2'b11, 4'b0001, 4'b0100, 2'b00, 0, 0, 0, 1, 0, 4'b0101, 3'b000, 4'b0001, 4'd0);

        for (int k = 1; k <= 20; k++) begin
            applyStimulus("stallSat", 0, 3'b001, 2'b00, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0,
                          0, 4'b0101, 3'b000, 4'b0001, 4'((k > 15) ? 15 : k));
        end
        applyStimulus("stallClr", 0, 3'b000, 2'b00, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0101, 3'b000, 4'b0001, 4'd0);

        applyStimulus("midRst1",  0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0101, 3'b000, 4'b0011, 4'd1);
        applyStimulus("midRst2",  0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0101, 3'b000, 4'b0011, 4'd2);
        applyStimulus("midRst",   1, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 4'b0000, 3'b000, 4'b0001, 4'd0);
        applyStimulus("postRst1", 0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 4'b0011, 4'd1);
        applyStimulus("postRst2", 0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 4'b0011, 4'd2);
        applyStimulus("postRst3", 0, 3'b001, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0011, 3'b000, 4'b0011, 4'd3);
        applyStimulus("finalEnd", 0, 3'b000, 2'b01, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 3'b000, 4'b0001, 4'd0);

        repeat (3) @(posedge clock);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending entries, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
